// File: rtl/modexp_ctrl.sv
// modexp_ctrl: left-to-right square-and-multiply modular exponentiation sequencer
// driving one shared Montgomery multiplier (result = base^exponent mod modulus).
// Ports:
//   clk_i, rst_ni            clock (rising edge), asynchronous active-low reset
//   start_i                  request, accepted only while idle
//   base_i, exponent_i,
//   modulus_i, r2_mod_i, r_i operands, sampled once on accept
//   busy_o, done_o, result_o status, one-cycle done pulse, held result
//   mm_*_o / mm_*_i          multiplier reset/enable/operand/done/result handshake
module modexp_ctrl #(
    parameter int WORD_WIDTH = 32,
    parameter int EXP_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [WORD_WIDTH-1:0] base_i,
    input  logic [EXP_WIDTH-1:0]  exponent_i,
    input  logic [WORD_WIDTH-1:0] modulus_i,
    input  logic [WORD_WIDTH-1:0] r2_mod_i,
    input  logic [WORD_WIDTH:0]   r_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [WORD_WIDTH-1:0] result_o,
    output logic                  mm_reset_o,
    output logic                  mm_enable_o,
    output logic [WORD_WIDTH-1:0] mm_m_o,
    output logic [WORD_WIDTH-1:0] mm_x_o,
    output logic [WORD_WIDTH-1:0] mm_y_o,
    output logic [WORD_WIDTH:0]   mm_r_o,
    input  logic                  mm_done_i,
    input  logic [WORD_WIDTH-1:0] mm_result_i
);
    localparam int BW = EXP_WIDTH > 1 ? $clog2(EXP_WIDTH) : 1;
    localparam logic [WORD_WIDTH-1:0] ONE = WORD_WIDTH'(1);
    typedef enum logic [2:0] {IDLE, MM_RST, MM_GO, MM_WAIT, NEXT, FIN} state_e;
    typedef enum logic [2:0] {OP_PRE_X, OP_PRE_A, OP_SQR, OP_MUL, OP_POST} op_e;
    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [EXP_WIDTH-1:0]  exp_q, exp_d;
    logic [WORD_WIDTH-1:0] base_q, base_d, r2_q, r2_d, m_q, m_d;
    logic [WORD_WIDTH-1:0] acc_q, acc_d, xbar_q, xbar_d, result_q, result_d;
    logic [WORD_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [WORD_WIDTH:0]   r_q, r_d;
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        bit_d    = bit_q;
        exp_d    = exp_q;
        base_d   = base_q;
        r2_d     = r2_q;
        m_d      = m_q;
        r_d      = r_q;
        acc_d    = acc_q;
        xbar_d   = xbar_q;
        result_d = result_q;
        x_d      = x_q;
        y_d      = y_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = MM_RST;
                op_d    = OP_PRE_X;
                base_d  = base_i;
                exp_d   = exponent_i;
                m_d     = modulus_i;
                r2_d    = r2_mod_i;
                r_d     = r_i;
            end
            MM_RST: state_d = MM_GO;
            MM_GO: state_d = MM_WAIT;
            MM_WAIT: if (mm_done_i) begin
                state_d  = NEXT;
                xbar_d   = op_q == OP_PRE_X ? mm_result_i : xbar_q;
                result_d = op_q == OP_POST ? mm_result_i : result_q;
                acc_d    = op_q inside {OP_PRE_A, OP_SQR, OP_MUL} ? mm_result_i : acc_q;
            end
            NEXT: begin
                state_d = MM_RST;
                case (op_q)
                    OP_PRE_X: op_d = OP_PRE_A;
                    OP_PRE_A: begin
                        op_d  = OP_SQR;
                        bit_d = BW'(EXP_WIDTH - 1);
                    end
                    OP_SQR, OP_MUL: begin
                        // A square on a set bit is followed by its multiply before moving on.
                        if (op_q == OP_SQR && exp_q[bit_q]) op_d = OP_MUL;
                        else if (bit_q == '0) op_d = OP_POST;
                        else begin
                            op_d  = OP_SQR;
                            bit_d = bit_q - 1'b1;
                        end
                    end
                    default: state_d = FIN;
                endcase
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Operands are latched on entry to MM_RST so they stay stable through the capture.
        if (state_d == MM_RST) begin
            x_d = op_d == OP_PRE_X ? base_d : op_d == OP_PRE_A ? ONE : acc_d;
            y_d = op_d inside {OP_PRE_X, OP_PRE_A} ? r2_d :
                  op_d == OP_SQR ? acc_d : op_d == OP_MUL ? xbar_d : ONE;
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            op_q     <= OP_PRE_X;
            bit_q    <= '0;
            exp_q    <= '0;
            base_q   <= '0;
            r2_q     <= '0;
            m_q      <= '0;
            r_q      <= '0;
            acc_q    <= '0;
            xbar_q   <= '0;
            result_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            bit_q    <= bit_d;
            exp_q    <= exp_d;
            base_q   <= base_d;
            r2_q     <= r2_d;
            m_q      <= m_d;
            r_q      <= r_d;
            acc_q    <= acc_d;
            xbar_q   <= xbar_d;
            result_q <= result_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end
    assign busy_o      = state_q != IDLE && state_q != FIN;
    assign done_o      = state_q == FIN;
    assign mm_reset_o  = state_q == MM_RST;
    assign mm_enable_o = state_q == MM_GO;
    assign result_o    = result_q;
    assign mm_m_o      = m_q;
    assign mm_r_o      = r_q;
    assign mm_x_o      = x_q;
    assign mm_y_o      = y_q;
endmodule

// File: tb/tb_modexp_ctrl.sv
// tb_modexp_ctrl: randomized self-checking bench for modexp_ctrl with a behavioural Montgomery multiplier
module tb_modexp_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_i = '0, exponent_i = '0, modulus_i = '0, r2_mod_i = '0;
    logic [32:0] r_i = '0;
    logic        busy, done, mm_reset, mm_enable, mm_done;
    logic [31:0] result, mm_m, mm_x, mm_y, mm_result;
    logic [32:0] mm_r;
    logic [31:0] mx, my, mmod;
    int          lat;
    int          errors = 0;
    int          checks = 0;
    int          lat_max = 4;

    always #5 clk = ~clk;

    modexp_ctrl #(.WORD_WIDTH(32), .EXP_WIDTH(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_i(base_i), .exponent_i(exponent_i),
        .modulus_i(modulus_i), .r2_mod_i(r2_mod_i), .r_i(r_i), .busy_o(busy), .done_o(done),
        .result_o(result), .mm_reset_o(mm_reset), .mm_enable_o(mm_enable), .mm_m_o(mm_m),
        .mm_x_o(mm_x), .mm_y_o(mm_y), .mm_r_o(mm_r), .mm_done_i(mm_done), .mm_result_i(mm_result)
    );

    // x*y*2^-32 mod m by bit-serial Montgomery reduction
    function automatic logic [31:0] mont(input logic [31:0] x, input logic [31:0] y, input logic [31:0] m);
        logic [33:0] t;
        t = '0;
        for (int i = 0; i < 32; i++) begin
            if (x[i]) t = t + 34'(y);
            if (t[0]) t = t + 34'(m);
            t = t >> 1;
        end
        if (t >= 34'(m)) t = t - 34'(m);
        return t[31:0];
    endfunction

    function automatic logic [31:0] pow_mod(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
        logic [63:0] r, bb, mm;
        mm = 64'(m);
        r  = 64'd1 % mm;
        bb = 64'(b) % mm;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * bb) % mm;
            bb = (bb * bb) % mm;
        end
        return r[31:0];
    endfunction

    function automatic logic [31:0] r2_of(input logic [31:0] m);
        logic [63:0] rm;
        rm = 64'h1_0000_0000 % 64'(m);
        rm = (rm * rm) % 64'(m);
        return rm[31:0];
    endfunction

    // Multiplier model: done rises a random number of cycles after enable and holds until mm_reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_done   <= 1'b0;
            mm_result <= '0;
            lat       <= 0;
        end else if (mm_reset) begin
            mm_done <= 1'b0;
            lat     <= 0;
        end else if (mm_enable) begin
            mx   <= mm_x;
            my   <= mm_y;
            mmod <= mm_m;
            lat  <= int'($urandom_range(1, lat_max));
        end else if (lat > 0) begin
            lat <= lat - 1;
            if (lat == 1) begin
                mm_done   <= 1'b1;
                mm_result <= mont(mx, my, mmod);
            end
        end
    end

    task automatic run_op(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m, input int poke,
                          output logic [31:0] res, output int ops, output int dones, output int busy_drops,
                          output bit timed_out);
        base_i = b; exponent_i = e; modulus_i = m; r2_mod_i = r2_of(m); r_i = 33'h1_0000_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ops = 0; dones = 0; busy_drops = 0; timed_out = 1'b1; res = '0;
        for (int c = 0; c < 5000; c++) begin
            if (c == poke) begin
                start = 1'b1; base_i = $urandom; exponent_i = $urandom; modulus_i = $urandom | 32'h1;
                r2_mod_i = $urandom;
            end
            if (c == poke + 2) start = 1'b0;
            if (mm_enable) ops++;
            if (done) begin
                dones++; res = result; timed_out = 1'b0;
                break;
            end
            if (!busy) busy_drops++;
            @(negedge clk);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) dones++;
            if (mm_enable) ops++;
        end
        if (timed_out) begin
            $display("FAIL timeout: no done within budget (base=%0d exp=%0d m=%0d)", b, e, m);
            errors++; checks++;
            rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, mm_reset, mm_enable} !== 4'b0) begin
            $display("FAIL reset_ctrl: busy/done/mm_reset/mm_enable=%b required 0000", {busy, done, mm_reset, mm_enable});
            errors++;
        end
        checks++;
        if ({result, mm_x, mm_y, mm_m, mm_r} !== '0) begin
            $display("FAIL reset_data: result=%0h mm_x=%0h mm_y=%0h mm_m=%0h mm_r=%0h required all 0", result, mm_x, mm_y, mm_m, mm_r);
            errors++;
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_op(input string name, input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
        logic [31:0] res, exp_res;
        int ops, dones, drops, exp_ops;
        bit to;
        run_op(b, e, m, -1, res, ops, dones, drops, to);
        exp_res = pow_mod(b, e, m);
        exp_ops = 3 + 32 + $countones(e);
        checks++;
        if (res !== exp_res) begin
            $display("FAIL %s result: got %0d required %0d", name, res, exp_res); errors++;
        end
        checks++;
        if (ops != exp_ops) begin
            $display("FAIL %s mm_ops: got %0d required %0d", name, ops, exp_ops); errors++;
        end
        checks++;
        if (dones != 1 || drops != 0) begin
            $display("FAIL %s handshake: done_pulses=%0d busy_low_cycles=%0d required 1 and 0", name, dones, drops); errors++;
        end
    endtask

    task automatic test_known_vectors();
        check_op("m13_b4_e13", 32'd4, 32'd13, 32'd13);
        checks++;
        if (result !== 32'd4) begin
            $display("FAIL m13_hold: result=%0d required 4", result); errors++;
        end
        check_op("m77_b2_e10", 32'd2, 32'd10, 32'd77);
        checks++;
        if (result !== 32'd23) begin
            $display("FAIL m77_value: result=%0d required 23", result); errors++;
        end
    endtask

    task automatic test_exp_edges();
        check_op("exp0", 32'd5, 32'd0, 32'd13);
        check_op("exp1", 32'd5, 32'd1, 32'd13);
        check_op("exp_all_ones", 32'd7, 32'hFFFF_FFFF, 32'd1_000_003);
        check_op("exp_msb_only", 32'd3, 32'h8000_0000, 32'h7FFF_FFFF);
    endtask

    task automatic test_start_ignored();
        logic [31:0] res;
        int ops, dones, drops;
        bit to;
        run_op(32'd4, 32'd13, 32'd13, 20, res, ops, dones, drops, to);
        checks++;
        if (res !== 32'd4 || dones != 1 || ops != 38) begin
            $display("FAIL start_while_busy: result=%0d dones=%0d ops=%0d required 4, 1, 38", res, dones, ops); errors++;
        end
    endtask

    task automatic test_reset_mid();
        int n;
        base_i = 32'd9; exponent_i = 32'd77; modulus_i = 32'd101; r2_mod_i = r2_of(32'd101);
        r_i = 33'h1_0000_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!mm_enable && n < 100) begin
            @(negedge clk); n++;
        end
        @(negedge clk);
        checks++;
        if (!busy || mm_enable || mm_reset) begin
            $display("FAIL mid_setup: busy=%b mm_enable=%b mm_reset=%b required 1 0 0", busy, mm_enable, mm_reset); errors++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, mm_reset, mm_enable} !== 4'b0 || {result, mm_x, mm_y, mm_m, mm_r} !== '0) begin
            $display("FAIL mid_reset_outputs: busy=%b done=%b result=%0h mm_x=%0h mm_y=%0h mm_m=%0h required all 0",
                     busy, done, result, mm_x, mm_y, mm_m); errors++;
        end
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) n++;
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done) n++;
        end
        checks++;
        if (n != 0) begin
            $display("FAIL mid_reset_done: done pulses=%0d required 0", n); errors++;
        end
        check_op("after_reset", 32'd9, 32'd77, 32'd101);
    endtask

    task automatic test_random();
        logic [31:0] m, b, e, res, exp_res;
        int ops, dones, drops;
        bit to;
        lat_max = 2;
        for (int k = 0; k < 150; k++) begin
            m = ($urandom & 32'h7FFF_FFFF) | 32'h1;
            if (m < 32'd3) m = 32'd3;
            b = $urandom % m;
            e = (k % 4 == 0) ? ($urandom & 32'hFF) : $urandom;
            run_op(b, e, m, -1, res, ops, dones, drops, to);
            exp_res = pow_mod(b, e, m);
            checks++;
            if (res !== exp_res || dones != 1) begin
                $display("FAIL random[%0d] b=%0d e=%0h m=%0d: got %0d dones=%0d required %0d dones=1", k, b, e, m, res, dones, exp_res);
                errors++;
            end
            checks++;
            if (ops != 35 + $countones(e)) begin
                $display("FAIL random_ops[%0d]: got %0d required %0d", k, ops, 35 + $countones(e)); errors++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_exp_edges();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
